// File: rtl/lsu_stage.sv
// Load/store unit behind the execute ALU: runs one word-addressed memory transaction per op,
// steers store lanes, extends load data and returns a single writeback or error pulse.
module lsu_stage #(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [4:0]        in_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              err_misalign,
    output logic              err_bus
);

    // state  | meaning
    // IDLE   | in_ready high, waiting for a load or store
    // REQ    | mem_req high, waiting for mem_gnt
    // WAIT_R | load granted, waiting for mem_rvalid
    // DONE   | one-cycle writeback or error pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    // Last wait cycle: an op waits at most TIMEOUT cycles in REQ or WAIT_R.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        op_store;
    logic        op_unsigned;
    logic [1:0]  op_size;
    logic [1:0]  op_lane;
    logic [4:0]  op_rd;

    logic        is_store;
    logic        misalign;
    logic [3:0]  strb_new;
    logic [31:0] wdata_new;
    logic [31:0] shifted;
    logic [31:0] load_val;

    assign is_store = in_store;

    always_comb begin
        case (in_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = in_addr[0];
            2'b10:   misalign = |in_addr[1:0];
            default: misalign = 1'b1;
        endcase
    end

    always_comb begin
        strb_new  = 4'b1111;
        wdata_new = in_wdata;
        case (in_size)
            2'b00: begin
                strb_new  = 4'b0001 << in_addr[1:0];
                wdata_new = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                strb_new  = in_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{in_wdata[15:0]}};
            end
            default: strb_new = 4'b1111;
        endcase
        if (!is_store) begin
            strb_new = 4'b0000;
        end
    end

    always_comb begin
        shifted = mem_rdata >> {op_lane, 3'b000};
        case (op_size)
            2'b00:   load_val = {{24{~op_unsigned & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~op_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            op_store     <= 1'b0;
            op_unsigned  <= 1'b0;
            op_size      <= '0;
            op_lane      <= '0;
            op_rd        <= '0;
            in_ready     <= 1'b1;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wstrb    <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            err_misalign <= 1'b0;
            err_bus      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            err_misalign <= 1'b0;
            err_bus      <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && (in_load || in_store)) begin
                        op_store    <= is_store;
                        op_unsigned <= in_unsigned;
                        op_size     <= in_size;
                        op_lane     <= in_addr[1:0];
                        op_rd       <= in_rd;
                        mem_we      <= is_store;
                        mem_addr    <= in_addr[ADDR_W+1:2];
                        mem_wstrb   <= strb_new;
                        mem_wdata   <= wdata_new;
                        cnt         <= '0;
                        in_ready    <= 1'b0;
                        if (misalign) begin
                            state        <= DONE;
                            err_misalign <= 1'b1;
                            wb_rd        <= '0;
                            wb_data      <= '0;
                        end else begin
                            state   <= REQ;
                            mem_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (op_store) begin
                            state    <= DONE;
                            wb_valid <= 1'b1;
                            wb_rd    <= '0;
                            wb_data  <= '0;
                        end else if (mem_rvalid) begin
                            // zero-latency read: data arrives with the grant
                            state    <= DONE;
                            wb_valid <= 1'b1;
                            wb_rd    <= op_rd;
                            wb_data  <= load_val;
                        end else begin
                            state <= WAIT_R;
                            cnt   <= '0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        err_bus <= 1'b1;
                        wb_rd   <= '0;
                        wb_data <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        state    <= DONE;
                        wb_valid <= 1'b1;
                        wb_rd    <= op_rd;
                        wb_data  <= load_val;
                    end else if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        err_bus <= 1'b1;
                        wb_rd   <= '0;
                        wb_data <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store unit sitting directly downstream of the execute ALU.
- Takes the effective byte address computed by the ALU (rs1 + imm) plus the store operand, and runs one word-addressed data-memory transaction over a req/gnt/rvalid handshake.
- Aligns, masks and sign/zero-extends data, then hands a single writeback beat to the register-file stage.
- Misaligned accesses are flagged, never issued.

Parameters:
- ADDR_W, 30, width of word address driven to data memory (byte address bits [31:2]).
- TIMEOUT, 255, max cycles waiting for mem_gnt or mem_rvalid before a bus error is raised; 8-bit counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  execute stage presents a memory op
- in_ready  output  1  LSU can accept op this cycle
- in_load  input  1  op is a load (lb/lh/lw/lbu/lhu)
- in_store  input  1  op is a store (sb/sh/sw); in_load and in_store both 1 treated as store
- in_size  input  2  00 byte, 01 half, 10 word, 11 reserved (misaligned error)
- in_unsigned  input  1  zero-extend load result (lbu/lhu)
- in_addr  input  32  effective byte address from ALU
- in_wdata  input  32  rs2 value for stores
- in_rd  input  5  destination register index for loads
- mem_req  output  1  memory request valid
- mem_we  output  1  write enable
- mem_addr  output  ADDR_W  word address = in_addr[31:2]
- mem_wstrb  output  4  byte lane enables
- mem_wdata  output  32  lane-shifted store data
- mem_gnt  input  1  memory accepted request this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read word
- wb_valid  output  1  one-cycle writeback pulse
- wb_rd  output  5  destination index (0 for stores)
- wb_data  output  32  extended load data (0 for stores)
- err_misalign  output  1  one-cycle pulse, misaligned or reserved-size op
- err_bus  output  1  one-cycle pulse, timeout expired

Behaviour:
- Reset: state IDLE; in_ready=1 after reset deassert; all other outputs 0.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - in_ready=1. Accept when in_valid & (in_load|in_store); in_valid with neither set is ignored.
  - Latch op, address, data and rd into registers.
  - Alignment rule: half requires addr[0]=0; word requires addr[1:0]=0; size 11 is always an error.
  - Misaligned: next state DONE with err_misalign=1, wb_valid=0, no mem_req ever asserted.
  - Aligned: next state REQ.
- REQ:
  - mem_req=1; mem_addr/we/wstrb/wdata held stable until mem_gnt.
  - Store wstrb: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111.
  - Store wdata: byte replicated to all 4 lanes; half replicated to both halves; word as-is.
  - Loads drive wstrb=0000.
  - On gnt, store: next DONE, wb_valid=1, wb_rd=0, wb_data=0.
  - On gnt, load: next WAIT_R, unless mem_rvalid is also 1 that cycle, which is a legal zero-latency read; then capture data and go to DONE.
- WAIT_R:
  - mem_req=0. On mem_rvalid, capture mem_rdata and go to DONE.
  - Lane select by latched addr[1:0]; sign-extend from bit 7/15 unless in_unsigned; word passes through.
- DONE:
  - Exactly one cycle. Drive wb_valid (or the err pulse) with registered wb_rd/wb_data, then return to IDLE.
  - in_ready=0 in REQ, WAIT_R and DONE.
  - Minimum latency from accept to wb_valid: 2 cycles (gnt and rvalid in the first REQ cycle).
- Timeout:
  - 8-bit counter clears on entry to REQ and on entry to WAIT_R, and increments each cycle in those states.
  - When it reaches TIMEOUT without the awaited gnt/rvalid, go to DONE with err_bus=1, wb_valid=0, mem_req dropped.
  - A late mem_rvalid arriving in IDLE after an error is ignored.
- Exclusivity: wb_valid, err_misalign and err_bus are mutually exclusive.
- Reset mid-transaction: immediate return to IDLE, mem_req=0 asynchronously, no writeback.

Test Plan:
- lw at addr 0x100, gnt in first REQ cycle, rvalid next cycle with rdata 0xDEADBEEF -> mem_addr=0x40, wb_valid with wb_data=0xDEADBEEF, wb_rd preserved.
- lb at 0x103 with rdata 0x80AA5511 -> wb_data=0xFFFFFF80. Same access as lbu -> 0x00000080. lh at 0x102 -> 0xFFFF80AA.
- sb at 0x101 with wdata 0x12345678 -> wstrb=0010, wdata=0x78787878. sh at 0x102 -> wstrb=1100, wdata=0x56785678. Each gives wb_valid with wb_rd=0.
- lw at 0x102, sh at 0x101, in_size=11 -> err_misalign pulse, mem_req never asserted, in_ready back to 1 two cycles after accept.
- Hold mem_gnt=0 for 300 cycles -> err_bus after TIMEOUT cycles, mem_req deasserts. Repeat with gnt given and rvalid withheld -> same result.
- Assert rst while in WAIT_R, then deliver rvalid -> mem_req=0 and in_ready=1 after reset release, no wb_valid; gnt and rvalid in the same cycle -> wb_valid 2 cycles after accept.
